// File: rtl/seg_execute_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : seg_execute_muldiv_pkg
//  Purpose : Shared MIPS execute-stage definitions. Holds the ALU control
//            codes, the multiply/divide opcode encodings, the default
//            datapath width and the multiply/divide FSM state type.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package seg_execute_muldiv_pkg;

  localparam int c_len_default = 32;
  localparam int c_nb_mdop     = 2;

  // ALU control codes used by the main execute ALU
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  // Multiply/divide unit opcodes
  typedef enum logic [1:0] {
    MDOP_MULT  = 2'b00,
    MDOP_MULTU = 2'b01,
    MDOP_DIV   = 2'b10,
    MDOP_DIVU  = 2'b11
  } mdop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/seg_execute_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module  : seg_execute_muldiv_if
//  Purpose : Request/result bundle of the multiply/divide unit.
//  Signals : i_start, i_mdop, i_data_a, i_data_b  (request, into the unit)
//            o_busy, o_done, o_hi, o_lo, o_div_zero (status/result, out)
//  Modports: master = requester, slave = multiply/divide unit
//  Rev     : 1.0  initial release
// ============================================================================
interface seg_execute_muldiv_if
  import seg_execute_muldiv_pkg::*;
#(
  parameter int LEN     = c_len_default,
  parameter int NB_MDOP = c_nb_mdop
) ();

  logic               i_start;
  logic [NB_MDOP-1:0] i_mdop;
  logic [LEN-1:0]     i_data_a;
  logic [LEN-1:0]     i_data_b;
  logic               o_busy;
  logic               o_done;
  logic [LEN-1:0]     o_hi;
  logic [LEN-1:0]     o_lo;
  logic               o_div_zero;

  modport master (
    output i_start, i_mdop, i_data_a, i_data_b,
    input  o_busy, o_done, o_hi, o_lo, o_div_zero
  );

  modport slave (
    input  i_start, i_mdop, i_data_a, i_data_b,
    output o_busy, o_done, o_hi, o_lo, o_div_zero
  );

endinterface
`default_nettype wire

// File: rtl/seg_execute_muldiv_dp.sv
`default_nettype none
// ============================================================================
//  Module  : seg_execute_muldiv_dp
//  Purpose : Iterative step datapath of the multiply/divide unit. Holds the
//            working accumulator (hi), the shifting operand (lo) and the
//            multiplicand/divisor magnitude. One shift-add (multiply) or
//            restoring shift-subtract (divide) step per i_step.
//  Ports   : i_clk, i_rst_n        clock, async active-low reset
//            i_load                capture operands (magnitudes + sign flags)
//            i_step                perform one iteration
//            i_mdop, i_data_a/b    operation and raw operands
//            o_fin_hi, o_fin_lo    sign-corrected result of the step in
//                                  progress (valid on the final step)
//  Rev     : 1.0  initial release
// ============================================================================
module seg_execute_muldiv_dp
  import seg_execute_muldiv_pkg::*;
#(
  parameter int LEN     = c_len_default,
  parameter int NB_MDOP = c_nb_mdop
) (
  input  wire logic               i_clk,
  input  wire logic               i_rst_n,
  input  wire logic               i_load,
  input  wire logic               i_step,
  input  wire logic [NB_MDOP-1:0] i_mdop,
  input  wire logic [LEN-1:0]     i_data_a,
  input  wire logic [LEN-1:0]     i_data_b,
  output logic      [LEN-1:0]     o_fin_hi,
  output logic      [LEN-1:0]     o_fin_lo
);

  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic [LEN-1:0]   r_hi;
  logic [LEN-1:0]   r_lo;
  logic [LEN-1:0]   r_b;

  logic             w_ld_div;
  logic             w_ld_signed;
  logic             w_sgn_a;
  logic             w_sgn_b;
  logic [LEN-1:0]   w_abs_a;
  logic [LEN-1:0]   w_abs_b;

  logic [LEN:0]     w_addend;
  logic [LEN:0]     w_msum;
  logic [LEN:0]     w_shift;
  logic [LEN-1:0]   w_dsub;
  logic             w_ge;
  logic [LEN-1:0]   w_nxt_hi;
  logic [LEN-1:0]   w_nxt_lo;
  logic [2*LEN-1:0] w_prod;
  logic [2*LEN-1:0] w_prod_neg;

  // ---- operand decode at load time ----
  assign w_ld_div    = (i_mdop == NB_MDOP'(MDOP_DIV)) || (i_mdop == NB_MDOP'(MDOP_DIVU));
  assign w_ld_signed = (i_mdop == NB_MDOP'(MDOP_DIV)) || (i_mdop == NB_MDOP'(MDOP_MULT));
  assign w_sgn_a     = w_ld_signed && i_data_a[LEN-1];
  assign w_sgn_b     = w_ld_signed && i_data_b[LEN-1];
  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude.
  assign w_abs_a     = w_sgn_a ? (-i_data_a) : i_data_a;
  assign w_abs_b     = w_sgn_b ? (-i_data_b) : i_data_b;

  // ---- multiply step: add multiplicand when lo[0] is set, shift {hi,lo} right ----
  assign w_addend = r_lo[0] ? {1'b0, r_b} : {(LEN+1){1'b0}};
  assign w_msum   = {1'b0, r_hi} + w_addend;

  // ---- divide step: shift the next dividend bit into the remainder ----
  assign w_shift  = {r_hi, r_lo[LEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_b});
  // When w_ge holds the difference is below the divisor and fits in LEN bits
  assign w_dsub   = w_shift[LEN-1:0] - r_b;

  always_comb begin
    w_nxt_hi = w_msum[LEN:1];
    w_nxt_lo = {w_msum[0], r_lo[LEN-1:1]};
    if (r_is_div) begin
      w_nxt_hi = w_ge ? w_dsub : w_shift[LEN-1:0];
      w_nxt_lo = {r_lo[LEN-2:0], w_ge};
    end
  end

  // ---- sign fix-up of the value produced by the current step ----
  assign w_prod     = {w_nxt_hi, w_nxt_lo};
  assign w_prod_neg = -w_prod;

  always_comb begin
    o_fin_hi = w_nxt_hi;
    o_fin_lo = w_nxt_lo;
    if (r_is_div) begin
      if (r_neg_lo) o_fin_lo = -w_nxt_lo;
      if (r_neg_hi) o_fin_hi = -w_nxt_hi;
    end else if (r_neg_lo) begin
      o_fin_hi = w_prod_neg[2*LEN-1:LEN];
      o_fin_lo = w_prod_neg[LEN-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (i_load) begin
      r_is_div <= w_ld_div;
      // product/quotient negate when signs differ; remainder follows dividend
      r_neg_lo <= w_sgn_a ^ w_sgn_b;
      r_neg_hi <= w_ld_div ? w_sgn_a : (w_sgn_a ^ w_sgn_b);
      r_hi     <= '0;
      r_lo     <= w_abs_a;
      r_b      <= w_abs_b;
    end else if (i_step) begin
      r_hi     <= w_nxt_hi;
      r_lo     <= w_nxt_lo;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module  : seg_execute_muldiv
//  Purpose : Iterative MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU).
//            IDLE -> RUN (LEN steps) -> DONE (one-cycle o_done pulse).
//            Divide by zero bypasses RUN and sets the sticky o_div_zero.
//  Ports   : i_clk     clock, rising edge
//            i_rst_n   asynchronous active-low reset
//            bus       seg_execute_muldiv_if.slave: i_start, i_mdop,
//                      i_data_a, i_data_b in; o_busy, o_done, o_hi, o_lo,
//                      o_div_zero out
//  Rev     : 1.0  initial release
// ============================================================================
module seg_execute_muldiv
  import seg_execute_muldiv_pkg::*;
#(
  parameter int LEN     = c_len_default,
  parameter int NB_MDOP = c_nb_mdop
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst_n,
  seg_execute_muldiv_if.slave  bus
);

  localparam int c_cnt_w = $clog2(LEN + 1);

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [LEN-1:0]     r_hi;
  logic [LEN-1:0]     r_lo;
  logic               r_div_zero;

  logic               w_is_div_in;
  logic               w_zero_div;
  logic               w_last;
  logic               w_load;
  logic               w_step;
  logic               w_busy;
  logic               w_done;
  logic [LEN-1:0]     w_fin_hi;
  logic [LEN-1:0]     w_fin_lo;

  assign w_is_div_in = (bus.i_mdop == NB_MDOP'(MDOP_DIV)) || (bus.i_mdop == NB_MDOP'(MDOP_DIVU));
  assign w_zero_div  = w_is_div_in && (bus.i_data_b == '0);
  assign w_last      = (r_cnt == c_cnt_w'(LEN - 1));

  // ---- FSM state register ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- FSM next state and control ----
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_state_nxt = w_zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- step counter and architectural result registers ----
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt      <= '0;
        r_div_zero <= w_zero_div;
        if (w_zero_div) begin
          r_hi <= bus.i_data_a;
          r_lo <= '1;
        end
      end
      if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        // results land only on the edge that enters DONE
        if (w_last) begin
          r_hi <= w_fin_hi;
          r_lo <= w_fin_lo;
        end
      end
    end
  end

  seg_execute_muldiv_dp #(
    .LEN     (LEN),
    .NB_MDOP (NB_MDOP)
  ) u_dp (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mdop   (bus.i_mdop),
    .i_data_a (bus.i_data_a),
    .i_data_b (bus.i_data_b),
    .o_fin_hi (w_fin_hi),
    .o_fin_lo (w_fin_lo)
  );

  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;
  assign bus.o_hi       = r_hi;
  assign bus.o_lo       = r_lo;
  assign bus.o_div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seg_execute_muldiv.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seg_execute_muldiv
//  Purpose : Self-checking bench for seg_execute_muldiv. Table of directed
//            vectors plus random operations checked against a behavioural
//            model; expected results go through a scoreboard queue and are
//            compared when o_done appears. Directed sequences cover the
//            ignored mid-RUN start and the reset abort.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_seg_execute_muldiv;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start_cyc;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  exp_t e_mon;

  seg_execute_muldiv_if #(.LEN(32), .NB_MDOP(2)) bus ();

  seg_execute_muldiv #(.LEN(32), .NB_MDOP(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    longint      la, lb;
    logic [63:0] p;
    int          sa, sb;
    r.dz = 1'b0; r.lat = 33; r.start_cyc = 0; r.hi = '0; r.lo = '0;
    case (op)
      2'b00: begin
        la = $signed(a); lb = $signed(b); p = la * lb;
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32]; r.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hffff_ffff; r.dz = 1'b1; r.lat = 1;
        end else if (op == 2'b11) begin
          r.lo = a / b; r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          sa = a; sb = b;
          r.lo = sa / sb; r.hi = sa % sb;
        end
      end
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT in IDLE; start is sampled at the next posedge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    exp_t x;
    x.hi = ehi; x.lo = elo; x.dz = edz;
    x.lat = (op[1] && b == 32'd0) ? 1 : 33;
    x.start_cyc = cyc + 1;
    sb_q.push_back(x);
    bus.i_start  = 1'b1;
    bus.i_mdop   = op;
    bus.i_data_a = a;
    bus.i_data_b = b;
    @(negedge clk);
    bus.i_start  = 1'b0;
    bus.i_data_a = $urandom;
    bus.i_data_b = $urandom;
    bus.i_mdop   = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout: %0d results pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard: every o_done pops one expected result
  always @(negedge clk) begin
    if (rst_n && bus.o_done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done: got o_done=1 required 0 (cycle %0d)", cyc);
      end else begin
        e_mon = sb_q.pop_front();
        check("hi", 64'(bus.o_hi), 64'(e_mon.hi));
        check("lo", 64'(bus.o_lo), 64'(e_mon.lo));
        check("div_zero", 64'(bus.o_div_zero), 64'(e_mon.dz));
        check("latency", 64'(cyc - e_mon.start_cyc + 1), 64'(e_mon.lat));
        check("busy_in_done", 64'(bus.o_busy), 64'd1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    n_tests = 0;
    n_fail  = 0;

    //          op     a             b             hi            lo            dz
    vecs[0]  = '{2'b01, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b00, 32'hfffffffd, 32'h00000002, 32'hffffffff, 32'hfffffffa, 1'b0};
    vecs[2]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[3]  = '{2'b10, 32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd, 1'b0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hffffffff, 1'b1};
    vecs[6]  = '{2'b01, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0};
    vecs[7]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hffffffff, 1'b1};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd, 1'b0};
    vecs[10] = '{2'b00, 32'h7fffffff, 32'hffffffff, 32'hffffffff, 32'h80000001, 1'b0};
    vecs[11] = '{2'b11, 32'hffffffff, 32'h00000001, 32'h00000000, 32'hffffffff, 1'b0};
    vecs[12] = '{2'b10, 32'hfffffff8, 32'hfffffffd, 32'hfffffffe, 32'h00000002, 1'b0};
    vecs[13] = '{2'b01, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};

    rst_n        = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_mdop   = 2'b00;
    bus.i_data_a = '0;
    bus.i_data_b = '0;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_hi", 64'(bus.o_hi), 64'd0);
    check("rst_lo", 64'(bus.o_lo), 64'd0);
    check("rst_div_zero", 64'(bus.o_div_zero), 64'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      wait_idle();
    end

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      m   = model(rop, ra, rb);
      run_op(rop, ra, rb, m.hi, m.lo, m.dz);
      wait_idle();
    end

    // start pulsed in RUN cycle 10 with new operands must be ignored
    run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (9) @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_mdop   = 2'b11;
    bus.i_data_a = 32'd100;
    bus.i_data_b = 32'd7;
    @(negedge clk);
    bus.i_start  = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // reset in RUN cycle 15 aborts the operation immediately
    run_op(2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_done", 64'(bus.o_done), 64'd0);
    check("abort_hi", 64'(bus.o_hi), 64'd0);
    check("abort_lo", 64'(bus.o_lo), 64'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b10, 32'hffffff9c, 32'd7, 32'hfffffffe, 32'hfffffff2, 1'b0);
    wait_idle();
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_execute_muldiv.md
SEG_EXECUTE_MULDIV -- requirements
Module: seg_execute_muldiv

Interface
REQ-001 SHALL have parameter LEN, default 32, operand/result width.
REQ-002 SHALL have parameter NB_MDOP, default 2, opcode width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port i_mdop  input  NB_MDOP  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 SHALL have port i_data_a  input  LEN  multiplicand / dividend (rs).
REQ-008 SHALL have port i_data_b  input  LEN  multiplier / divisor (rt).
REQ-009 SHALL have port o_busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse; o_hi/o_lo valid.
REQ-011 SHALL have port o_hi  output  LEN  HI register: product upper half / remainder.
REQ-012 SHALL have port o_lo  output  LEN  LO register: product lower half / quotient.
REQ-013 SHALL have port o_div_zero  output  1  sticky flag: last DIV/DIVU had divisor 0.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE and i_start=1 SHALL latch i_mdop, i_data_a, i_data_b, clear step counter, go to RUN.
REQ-016 IDLE and i_start=0 SHALL stay in IDLE with all outputs held.
REQ-017 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle for exactly LEN cycles, then go to DONE.
REQ-018 DONE SHALL last one cycle with o_done=1, then return to IDLE.
REQ-019 o_hi/o_lo SHALL update only on the edge entering DONE and hold until the next DONE.
REQ-020 Latency SHALL be LEN+1 cycles from the start-sampling edge to o_done=1 (33 for LEN=32).
REQ-021 i_start in RUN or DONE SHALL be ignored; no queuing.
REQ-022 Signed ops SHALL run on magnitudes; product is negated if operand signs differ, quotient if signs differ, and remainder takes the dividend's sign.
REQ-023 MULT/MULTU SHALL yield the full 2*LEN-bit product: {o_hi,o_lo}.
REQ-024 DIV of most-negative value by -1 SHALL give o_lo=0x80000000, o_hi=0 (wrap, no flag).
REQ-025 DIV/DIVU with i_data_b=0 SHALL skip RUN (IDLE->DONE in one cycle), set o_lo=all ones, o_hi=i_data_a, o_div_zero=1.
REQ-026 o_div_zero SHALL clear at the next accepted start that is not a divide-by-zero.
REQ-027 Operand inputs SHALL be don't-care after the start-sampling edge.

Reset
REQ-028 i_rst_n=0 SHALL force IDLE, o_busy=0, o_done=0, o_hi=0, o_lo=0, o_div_zero=0, counter=0 immediately, regardless of clock.
REQ-029 Reset mid-RUN SHALL abort; no o_done pulse for the aborted operation.
REQ-030 First start SHALL be accepted on the first rising edge with i_rst_n=1.

Structure
REQ-031 The opcode encodings (MULT/MULTU/DIV/DIVU) and default LEN SHALL live in the shared MIPS package, beside the ALU control codes.
REQ-032 The step datapath (accumulator, shift, add/subtract, sign fix-up) SHALL be one sub-module, seg_execute_muldiv_dp; the FSM and counter stay in the top.

Verification
REQ-033 MULTU 0xFFFFFFFF*0xFFFFFFFF SHALL give o_done at cycle 33, o_hi=0xFFFFFFFE, o_lo=0x00000001.
REQ-034 MULT -3*2 SHALL give o_hi=0xFFFFFFFF, o_lo=0xFFFFFFFA; DIVU 7/2 SHALL give o_lo=3, o_hi=1.
REQ-035 DIV -7/2 SHALL give o_lo=0xFFFFFFFD, o_hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF SHALL give o_lo=0x80000000, o_hi=0.
REQ-036 DIVU 5/0 SHALL give o_done 1 cycle after start, o_lo=0xFFFFFFFF, o_hi=5, o_div_zero=1; a following MULTU 1*1 SHALL clear o_div_zero.
REQ-037 i_start pulsed at cycle 10 of RUN with new operands SHALL be ignored: one o_done only, results from the original operands.
REQ-038 i_rst_n low at cycle 15 of RUN SHALL give o_busy=0, o_hi=o_lo=0 immediately, with no o_done; a new start afterward SHALL complete normally.
